// File: rtl/rvfi_pc_chain_check.sv
// rvfi_pc_chain_check: PC continuity checker over a window of DEPTH+1 consecutive retirement orders
module rvfi_pc_chain_check #(
  parameter int XLEN = 32,
  parameter int NRET = 1,
  parameter int DEPTH = 4,
  parameter int ALIGN_LSB = 1,
  parameter bit BWD_ONLY = 1'b0,
  localparam int LW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 check,
  input  logic [63:0]          insn_order,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  output logic                 err,
  output logic [LW-1:0]        err_link,
  output logic                 err_dup,
  output logic                 covered,
  output logic                 incomplete
);
  localparam int D = BWD_ONLY ? 1 : DEPTH;
  localparam int NS = D + 1;
  logic [NS-1:0] v, hit, dup;
  logic [XLEN-1:0] rd [NS];
  logic [XLEN-1:0] wd [NS];
  logic [XLEN-1:0] nrd [NS];
  logic [XLEN-1:0] nwd [NS];
  logic [D-1:0] rdy, mis;
  logic [LW-1:0] nl;
  logic [63:0] o;
  // Orders below insn_order (including wrapped ones) never match a slot offset.
  always_comb begin
    hit = '0;
    dup = '0;
    o = '0;
    for (int s = 0; s < NS; s++) begin
      nrd[s] = rd[s];
      nwd[s] = wd[s];
    end
    for (int c = 0; c < NRET; c++) begin
      o = rvfi_order[64*c +: 64];
      for (int s = 0; s < NS; s++)
        if (rvfi_valid[c] && o >= insn_order && o - insn_order == 64'(s)) begin
          if (v[s] || hit[s]) dup[s] = 1'b1;
          else begin
            nrd[s] = rvfi_pc_rdata[XLEN*c +: XLEN];
            nwd[s] = rvfi_pc_wdata[XLEN*c +: XLEN];
          end
          hit[s] = 1'b1;
        end
    end
  end
  // Lowest failing link wins; any duplicate overrides a mismatch.
  always_comb begin
    rdy = '0;
    mis = '0;
    nl = '0;
    for (int k = 0; k < D; k++) begin
      rdy[k] = v[k] & v[k+1];
      mis[k] = rdy[k] && ((wd[k] >> ALIGN_LSB) != (rd[k+1] >> ALIGN_LSB));
    end
    for (int k = D - 1; k >= 0; k--)
      if (mis[k]) nl = LW'(k);
    for (int s = NS - 1; s >= 0; s--)
      if (dup[s]) nl = LW'(s < D ? s : D - 1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      v <= '0;
      err <= 1'b0;
      err_link <= '0;
      err_dup <= 1'b0;
      covered <= 1'b0;
      incomplete <= 1'b0;
    end else begin
      v <= v | hit;
      for (int s = 0; s < NS; s++) begin
        rd[s] <= nrd[s];
        wd[s] <= nwd[s];
      end
      if (!err && (|dup || |mis)) begin
        err <= 1'b1;
        err_link <= nl;
        err_dup <= |dup;
      end
      if (&rdy) covered <= 1'b1;
      if (check && !covered) incomplete <= 1'b1;
    end
  end
endmodule
